// File: rtl/pprm_pkg.sv
// Shared GF(2^4) definitions for the PPRM S-box inverter stages (poly basis, x^4 + x + 1).
package pprm_pkg;

    localparam int NIB_W = 4;
    localparam logic [NIB_W-1:0] GF4_POLY = 4'b0011;

    function automatic logic [NIB_W-1:0] gf4_inv(input logic [NIB_W-1:0] x);
        logic [NIB_W-1:0] r;
        case (x)
            4'h0: r = 4'h0;
            4'h1: r = 4'h1;
            4'h2: r = 4'h9;
            4'h3: r = 4'hE;
            4'h4: r = 4'hD;
            4'h5: r = 4'hB;
            4'h6: r = 4'h7;
            4'h7: r = 4'h6;
            4'h8: r = 4'hF;
            4'h9: r = 4'h2;
            4'hA: r = 4'hC;
            4'hB: r = 4'h5;
            4'hC: r = 4'hA;
            4'hD: r = 4'h4;
            4'hE: r = 4'h3;
            default: r = 4'h8;
        endcase
        return r;
    endfunction

    function automatic logic [NIB_W-1:0] gf4_mul(input logic [NIB_W-1:0] a, input logic [NIB_W-1:0] b);
        logic [NIB_W-1:0] p;
        logic [NIB_W-1:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < NIB_W; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[NIB_W-2:0], 1'b0} ^ (t[NIB_W-1] ? GF4_POLY : '0);
        end
        return p;
    endfunction

endpackage

// File: rtl/pprm_gf4_inv.sv
// Combinational GF(2^4) inverter, 0 maps to 0; zero latency, no flow control.
module pprm_gf4_inv
    import pprm_pkg::*;
(
    input  logic [NIB_W-1:0] c,
    output logic [NIB_W-1:0] d
);

    assign d = gf4_inv(c);

endmodule

// File: rtl/pprm_stage_2_pipe.sv
// PPRM stage 2: D = C^-1 with A/B aligned; latency REG_IN+1 slots, valid/ready.
// Backpressure holds every slot stable; an empty slot always accepts, so bubbles collapse.
module pprm_stage_2_pipe
    import pprm_pkg::*;
#(
    parameter int REG_IN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [3:0]       in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic [3:0]       out_b,
    output logic [3:0]       out_d,
    output logic [CNT_W-1:0] zero_cnt,
    input  logic             clr_cnt
);

    logic             s2_v;
    logic [NIB_W-1:0] s2_a, s2_b, s2_d;
    logic             s2_adv;
    logic             in_xfer;

    // Feed into S2: either the S1 slot or the raw input, depending on REG_IN.
    logic             st_v;
    logic [NIB_W-1:0] st_a, st_b, st_c, st_d;

    assign s2_adv  = !s2_v || out_ready;
    assign in_xfer = in_valid && in_ready;

    generate
        if (REG_IN != 0) begin : g_reg_in
            logic             s1_v;
            logic [NIB_W-1:0] s1_a, s1_b, s1_c;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_v <= 1'b0;
                    s1_a <= '0;
                    s1_b <= '0;
                    s1_c <= '0;
                end else if (in_ready) begin
                    s1_v <= in_valid;
                    if (in_valid) begin
                        s1_a <= in_a;
                        s1_b <= in_b;
                        s1_c <= in_c;
                    end
                end
            end

            assign in_ready = !s1_v || s2_adv;
            assign st_v     = s1_v;
            assign st_a     = s1_a;
            assign st_b     = s1_b;
            assign st_c     = s1_c;
        end else begin : g_no_reg
            assign in_ready = s2_adv;
            assign st_v     = in_valid;
            assign st_a     = in_a;
            assign st_b     = in_b;
            assign st_c     = in_c;
        end
    endgenerate

    pprm_gf4_inv u_inv (
        .c (st_c),
        .d (st_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_a <= '0;
            s2_b <= '0;
            s2_d <= '0;
        end else if (s2_adv) begin
            s2_v <= st_v;
            if (st_v) begin
                s2_a <= st_a;
                s2_b <= st_b;
                s2_d <= st_d;
            end
        end
    end

    // Counts at the input side, so output stalls never affect it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt <= '0;
        end else if (clr_cnt) begin
            zero_cnt <= '0;
        end else if (in_xfer && (in_c == 4'h0) && (zero_cnt != '1)) begin
            zero_cnt <= zero_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_v;
    assign out_a     = s2_a;
    assign out_b     = s2_b;
    assign out_d     = s2_d;

endmodule

// File: tb/tb_pprm_stage_2_pipe.sv
// Directed bench for pprm_stage_2_pipe: reset, streaming, stall, scoreboard, counter and mid-flight reset.
module tb_pprm_stage_2_pipe;
    import pprm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic clr_cnt = 1'b0;
    logic [3:0] in_a = '0, in_b = '0, in_c = '0;

    logic        in_ready, out_valid;
    logic [3:0]  out_a, out_b, out_d;
    logic [15:0] zero_cnt;

    logic        sat_in_ready, sat_out_valid;
    logic [3:0]  sat_out_a, sat_out_b, sat_out_d;
    logic [1:0]  sat_zero_cnt;

    logic        nr_in_ready, nr_out_valid;
    logic [3:0]  nr_out_a, nr_out_b, nr_out_d;
    logic [15:0] nr_zero_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] inv_tab [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                                 4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    always #5 clk = ~clk;

    pprm_stage_2_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_d(out_d),
        .zero_cnt(zero_cnt), .clr_cnt(clr_cnt)
    );

    pprm_stage_2_pipe #(.REG_IN(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_a(sat_out_a), .out_b(sat_out_b), .out_d(sat_out_d),
        .zero_cnt(sat_zero_cnt), .clr_cnt(clr_cnt)
    );

    pprm_stage_2_pipe #(.REG_IN(0), .CNT_W(16)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nr_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(nr_out_valid),
        .out_ready(out_ready), .out_a(nr_out_a), .out_b(nr_out_b), .out_d(nr_out_d),
        .zero_cnt(nr_zero_cnt), .clr_cnt(clr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] q[$];
        logic [11:0] e;
        int tx, rx, cyc;

        // Reset with valid held high.
        in_valid = 1'b1;
        in_a = 4'h1; in_b = 4'h2; in_c = 4'h3;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_zero_cnt", zero_cnt, 0);
        chk("rst_nr_out_valid", nr_out_valid, 0);
        rst = 1'b0;
        #1 chk("rel_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lat_first_edge", out_valid, 0);
        chk("lat_nr_valid", nr_out_valid, 1);
        chk("lat_nr_d", nr_out_d, 4'hE);
        step();
        chk("lat_second_edge", out_valid, 1);
        chk("lat_d", out_d, 4'hE);
        chk("lat_ab", {out_a, out_b}, 8'h12);
        step();
        chk("lat_drained", out_valid, 0);

        // Stream C = 0..F with out_ready high.
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                in_valid = 1'b1;
                in_a = 4'h5; in_b = 4'hA; in_c = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i < 16) begin
                chk("nr_stream_d", {nr_out_valid, nr_out_d}, {1'b1, inv_tab[i]});
            end
            if (i >= 1) begin
                chk("stream_d", {out_valid, out_d}, {1'b1, inv_tab[i-1]});
                chk("stream_ab", {out_a, out_b}, 8'h5A);
            end
            if (i >= 2) begin
                chk("stream_mul_one", gf4_mul(4'(i-1), out_d), 1);
            end
        end
        step();
        chk("stream_drained", out_valid, 0);
        chk("stream_cnt", zero_cnt, 1);

        // Backpressure: C = 2,3,4 with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'h7; in_b = 4'h8; in_c = 4'h2;
        #1 chk("bp_rdy0", in_ready, 1);
        step();
        in_c = 4'h3;
        #1 chk("bp_rdy1", in_ready, 1);
        step();
        in_c = 4'h4;
        #1 chk("bp_rdy_full", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold", {out_valid, out_d, out_a, out_b}, {1'b1, 4'h9, 4'h7, 4'h8});
            chk("bp_rdy_low", in_ready, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_rdy_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("bp_out1", {out_valid, out_d}, {1'b1, 4'hE});
        step();
        chk("bp_out2", {out_valid, out_d}, {1'b1, 4'hD});
        step();
        chk("bp_empty", out_valid, 0);

        // Random handshakes against a scoreboard queue.
        tx = 0; rx = 0; cyc = 0;
        while ((tx < 2000 || rx < 2000) && cyc < 20000) begin
            in_valid  = (tx < 2000) && ($urandom_range(0, 3) != 0);
            in_a      = 4'($urandom_range(0, 15));
            in_b      = 4'($urandom_range(0, 15));
            in_c      = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_extra_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_beat", {out_a, out_b, out_d}, e);
                end
                rx++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_a, in_b, inv_tab[in_c]});
                tx++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("sb_rx_count", rx, 2000);
        chk("sb_queue_empty", q.size(), 0);
        out_ready = 1'b1;
        step();
        chk("sb_no_dup", out_valid, 0);

        // Zero counter: clear, count, saturate, clear-over-increment.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("cnt_clr", zero_cnt, 0);
        chk("cnt_sat_clr", sat_zero_cnt, 0);
        in_valid = 1'b1; in_c = 4'h0;
        repeat (3) step();
        in_valid = 1'b0;
        chk("cnt_three", zero_cnt, 3);
        chk("cnt_sat_three", sat_zero_cnt, 3);
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        chk("cnt_six", zero_cnt, 6);
        chk("cnt_sat_hold", sat_zero_cnt, 3);
        in_valid = 1'b1; clr_cnt = 1'b1;
        step();
        in_valid = 1'b0; clr_cnt = 1'b0;
        chk("cnt_clr_prio", zero_cnt, 0);
        chk("cnt_sat_clr_prio", sat_zero_cnt, 0);
        repeat (3) step();

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_c = 4'h5;
        step();
        in_c = 4'h6;
        step();
        in_valid = 1'b0;
        chk("fl_loaded", {out_valid, out_d}, {1'b1, 4'hB});
        #2 rst = 1'b1;
        #1;
        chk("fl_async_valid", out_valid, 0);
        chk("fl_async_d", out_d, 0);
        chk("fl_async_rdy", in_ready, 1);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fl_no_ghost", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
